// File: rtl/alu_shift_sequencer_pkg.sv
// Shared ALU definitions: control codes, shift-op encodings and sequencer states.
// Also consumed by the ALU and the ALU control decoder.
package alu_defs;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;
    localparam logic [3:0] ALU_PASS = 4'hA;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    function automatic logic [3:0] shift_code(input logic [1:0] op);
        case (op)
            OP_SLL:  shift_code = ALU_SLL;
            OP_SRL:  shift_code = ALU_SRL;
            OP_SRA:  shift_code = ALU_SRA;
            default: shift_code = ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/alu_shift_sequencer_counter.sv
// Loadable down-counter tracking the remaining single-bit shift steps.
// Never decrements below zero; last flags the final iteration.
module shift_counter #(
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [SHW-1:0] load_val,
    input  logic           dec,
    output logic           last
);

    logic [SHW-1:0] cnt_r;

    // count register: load wins over decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != '0)) begin
            cnt_r <= cnt_r - SHW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last = (cnt_r == SHW'(1));

endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shift sequencer: drives a single-bit-shift ALU once per cycle,
// accumulating its output until the full shift amount has been applied.
module alu_shift_sequencer
    import alu_defs::*;
#(
    parameter int n   = 32,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [n-1:0]   operand,
    input  logic [SHW-1:0] shamt,
    output logic [n-1:0]   alu_a,
    output logic [3:0]     alu_control,
    output logic           alu_sel,
    input  logic [n-1:0]   alu_result,
    output logic           busy,
    output logic           stall,
    output logic           done,
    output logic [n-1:0]   result
);

    state_t       state_r, state_s;
    logic         accept_s, shift_go_s, last_s;
    logic [1:0]   op_q_r, op_next_s;
    logic [n-1:0] acc_r;

    shift_counter #(.SHW(SHW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .load_val (shamt),
        .dec      (state_r == ST_SHIFT),
        .last     (last_s)
    );

    // next-state and accept decode
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        shift_go_s = 1'b0;
        op_next_s  = op_q_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept_s  = 1'b1;
                    op_next_s = op;
                    if ((shamt != '0) && (op != OP_RSV)) begin
                        shift_go_s = 1'b1;
                        state_s    = ST_SHIFT;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // accumulator, result and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= '0;
            op_q_r      <= OP_SLL;
            result      <= '0;
            busy        <= 1'b0;
            alu_sel     <= 1'b0;
            done        <= 1'b0;
            alu_control <= ALU_PASS;
        end else begin
            if (accept_s) begin
                acc_r  <= operand;
                op_q_r <= op;
                if (!shift_go_s) begin
                    result <= operand;
                end else begin
                    result <= result;
                end
            end else if (state_r == ST_SHIFT) begin
                acc_r <= alu_result;
                if (last_s) begin
                    result <= alu_result;
                end else begin
                    result <= result;
                end
            end else begin
                acc_r <= acc_r;
            end
            busy        <= (state_s == ST_SHIFT);
            alu_sel     <= (state_s == ST_SHIFT);
            done        <= (state_s == ST_DONE);
            alu_control <= (state_s == ST_SHIFT) ? shift_code(op_next_s) : ALU_PASS;
        end
    end

    assign alu_a = acc_r;
    assign stall = (start && ((state_r == ST_IDLE) || (state_r == ST_DONE)))
                   || (state_r == ST_SHIFT);

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Bench for alu_shift_sequencer: single-bit-shift ALU stub, timeline-based
// reference model checked every cycle, plus directed literal expectations.
module tb_alu_shift_sequencer;
    import alu_defs::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand = 32'h0;
    logic [4:0]  shamt = 5'd0;
    logic [31:0] alu_a, alu_result, result;
    logic [3:0]  alu_control;
    logic        alu_sel, busy, stall, done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_shift_sequencer #(.n(32), .SHW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .operand(operand),
        .shamt(shamt), .alu_a(alu_a), .alu_control(alu_control),
        .alu_sel(alu_sel), .alu_result(alu_result), .busy(busy),
        .stall(stall), .done(done), .result(result)
    );

    // single-bit shift ALU stub
    always_comb begin
        case (alu_control)
            ALU_SLL: alu_result = alu_a << 1;
            ALU_SRL: alu_result = alu_a >> 1;
            ALU_SRA: alu_result = {alu_a[31], alu_a[31:1]};
            default: alu_result = alu_a;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] x, input int s);
        case (o)
            2'b00:   return x << s;
            2'b01:   return x >> s;
            2'b10:   return 32'($signed(x) >>> s);
            default: return x;
        endcase
    endfunction

    function automatic logic [3:0] ref_code(input logic [1:0] o);
        case (o)
            2'b00:   return 4'h5;
            2'b01:   return 4'h6;
            2'b10:   return 4'h7;
            default: return 4'hA;
        endcase
    endfunction

    // model: an accepted op at cycle t0 with effective amount k is busy in
    // cycles t0+1..t0+k and done in cycle t0+k+1
    bit          m_active = 1'b0;
    int          m_t0 = 0;
    int          m_k  = 0;
    logic [1:0]  m_op = 2'b00;
    logic [31:0] m_opnd = 32'h0;
    logic [31:0] m_next = 32'h0;
    logic [31:0] m_result = 32'h0;

    always @(negedge clk) begin
        bit busy_e, done_e;
        busy_e = m_active && (cyc > m_t0) && (cyc <= m_t0 + m_k);
        done_e = m_active && (cyc == m_t0 + m_k + 1);
        if (done_e) m_result = m_next;
        if (chk_en) begin
            chk("m_busy", 32'(busy), 32'(busy_e));
            chk("m_alu_sel", 32'(alu_sel), 32'(busy_e));
            chk("m_done", 32'(done), 32'(done_e));
            chk("m_stall", 32'(stall), 32'(busy_e || (start && !busy_e)));
            chk("m_result", result, m_result);
            chk("m_alu_control", 32'(alu_control), 32'(busy_e ? ref_code(m_op) : 4'hA));
            if (busy_e) chk("m_alu_a", alu_a, ref_shift(m_op, m_opnd, cyc - m_t0 - 1));
        end
        if (rst) begin
            m_active = 1'b0;
            m_result = 32'h0;
        end else if (start && !busy_e) begin
            m_active = 1'b1;
            m_t0     = cyc;
            m_op     = op;
            m_opnd   = operand;
            m_k      = (op == 2'b11) ? 0 : int'(shamt);
            m_next   = ref_shift(op, operand, m_k);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [4:0] s);
        op = o; operand = x; shamt = s; start = 1'b1;
        #1;
        chk("stall_on_start", 32'(stall), 32'h1);
    endtask

    task automatic wait_done(input int c0, input int exp_lat, input logic [31:0] exp_res, input string tag);
        int lat;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                lat = cyc - c0;
                break;
            end
            tick();
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, result, exp_res);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [4:0] s,
                          input int exp_lat, input logic [31:0] exp_res, input string tag);
        int c0;
        c0 = cyc;
        issue(o, x, s);
        tick();
        start = 1'b0;
        wait_done(c0, exp_lat, exp_res, tag);
        tick();
    endtask

    initial begin
        int c0;
        int late_done;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_alu_sel", 32'(alu_sel), 32'h0);
        chk("rst_alu_control", 32'(alu_control), 32'hA);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_result", result, 32'h0);
        tick();

        run_op(2'b00, 32'h0000_0001, 5'd4, 5, 32'h0000_0010, "sll4");
        run_op(2'b10, 32'h8000_0000, 5'd31, 32, 32'hFFFF_FFFF, "sra31");
        run_op(2'b01, 32'h8000_0000, 5'd31, 32, 32'h0000_0001, "srl31");
        run_op(2'b00, 32'h1234_5678, 5'd0, 1, 32'h1234_5678, "shamt0");
        run_op(2'b11, 32'h1234_5678, 5'd7, 1, 32'h1234_5678, "op11");
        run_op(2'b10, 32'h7000_0000, 5'd3, 4, 32'h0E00_0000, "sra_pos");

        // start during SHIFT is ignored
        c0 = cyc;
        issue(2'b00, 32'h0000_0003, 5'd5);
        tick();
        start = 1'b0;
        tick();
        op = 2'b01; operand = 32'h0000_FFFF; shamt = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(c0, 6, 32'h0000_0060, "ignored_start");
        tick();

        // back-to-back start in the DONE cycle
        c0 = cyc;
        issue(2'b00, 32'h0000_0001, 5'd2);
        tick();
        start = 1'b0;
        wait_done(c0, 3, 32'h0000_0004, "b2b_first");
        c0 = cyc;
        issue(2'b01, 32'h0000_00F0, 5'd4);
        tick();
        start = 1'b0;
        wait_done(c0, 5, 32'h0000_000F, "b2b_second");
        tick();

        // reset in cycle 3 of a shamt=8 shift
        c0 = cyc;
        issue(2'b00, 32'h0000_00A5, 5'd8);
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_alu_sel", 32'(alu_sel), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_result", result, 32'h0);
        late_done = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) late_done++;
            tick();
        end
        chk("midrst_no_late_done", 32'(late_done), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
